// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - request scheduler sharing the sdram command port between write, read and refresh
// Optional feature macro: SDRAM_ARB_REF_POSTPONE_EN (owed-refresh counter with postponement).
module sdram_arb #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 64,
    parameter int REF_PERIOD = 390
`ifdef SDRAM_ARB_REF_POSTPONE_EN
    ,
    parameter int REF_MAX_OWED = 8
`endif
) (
    input  logic              clock,
    input  logic              srst_n,
    input  logic              init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    input  logic [DATA_W-1:0] cmd_rdata,
    output logic              ref_overrun
);
    localparam int CNT_W = $clog2(REF_PERIOD + 1);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_REF  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              last_grant_q, last_grant_d;  // 1: the last data grant went to the writer
    logic              is_rd_q, is_rd_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [1:0]        cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              ref_overrun_q, ref_overrun_d;
`ifdef SDRAM_ARB_REF_POSTPONE_EN
    localparam int OWED_W = $clog2(REF_MAX_OWED + 1);
    logic [OWED_W-1:0] ref_owed_q, ref_owed_d;
`else
    logic              ref_pend_q, ref_pend_d;
`endif
    logic tick, ref_want, can_grant, grant_ref, grant_wr, grant_rd;

    always_comb begin
        tick      = init_done && (ref_cnt_q == CNT_W'(REF_PERIOD - 1));
        ref_cnt_d = (!init_done || tick) ? '0 : ref_cnt_q + CNT_W'(1);

`ifdef SDRAM_ARB_REF_POSTPONE_EN
        // Data traffic may defer refresh until the owed count is at its limit.
        ref_want = (ref_owed_q != '0) &&
                   (!(wr_req || rd_req) || (ref_owed_q == OWED_W'(REF_MAX_OWED)));
`else
        ref_want = ref_pend_q;
`endif
        can_grant = (state_q == IDLE) && init_done;
        grant_ref = can_grant && ref_want;
        grant_wr  = can_grant && !ref_want && wr_req && (!rd_req || !last_grant_q);
        grant_rd  = can_grant && !ref_want && rd_req && (!wr_req || last_grant_q);

        ref_overrun_d = ref_overrun_q;
`ifdef SDRAM_ARB_REF_POSTPONE_EN
        ref_owed_d = ref_owed_q;
        if (tick && !grant_ref) begin
            if (ref_owed_q == OWED_W'(REF_MAX_OWED)) begin
                ref_overrun_d = 1'b1;
            end else begin
                ref_owed_d = ref_owed_q + OWED_W'(1);
            end
        end else if (!tick && grant_ref) begin
            ref_owed_d = ref_owed_q - OWED_W'(1);
        end
`else
        ref_pend_d = tick || (ref_pend_q && !grant_ref);
        if (tick && ref_pend_q) begin
            ref_overrun_d = 1'b1;
        end
`endif

        state_d      = state_q;
        last_grant_d = last_grant_q;
        is_rd_d      = is_rd_q;
        wr_ack_d     = 1'b0;
        rd_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_op_d     = cmd_op_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_ref || grant_wr || grant_rd) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    is_rd_d     = grant_rd;
                end
                if (grant_ref) begin
                    cmd_op_d   = OP_REF;
                    cmd_addr_d = '0;
                end else if (grant_wr) begin
                    cmd_op_d     = OP_WR;
                    cmd_addr_d   = wr_addr;
                    cmd_wdata_d  = wr_data;
                    wr_ack_d     = 1'b1;
                    last_grant_d = 1'b1;
                end else if (grant_rd) begin
                    cmd_op_d     = OP_RD;
                    cmd_addr_d   = rd_addr;
                    rd_ack_d     = 1'b1;
                    last_grant_d = 1'b0;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OP_NONE;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd_done) begin
                    if (is_rd_q) begin
                        rd_data_d  = cmd_rdata;
                        rd_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!srst_n) begin
            state_q       <= IDLE;
            ref_cnt_q     <= '0;
            last_grant_q  <= 1'b0;
            is_rd_q       <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= OP_NONE;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            ref_overrun_q <= 1'b0;
`ifdef SDRAM_ARB_REF_POSTPONE_EN
            ref_owed_q    <= '0;
`else
            ref_pend_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            last_grant_q  <= last_grant_d;
            is_rd_q       <= is_rd_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            ref_overrun_q <= ref_overrun_d;
`ifdef SDRAM_ARB_REF_POSTPONE_EN
            ref_owed_q    <= ref_owed_d;
`else
            ref_pend_q    <= ref_pend_d;
`endif
        end
    end

    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_wdata   = cmd_wdata_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
- Request scheduler in front of the sdram command core.
- Shares the single-burst command port between a write requester, a read requester and an internal periodic refresh timer.
- Arbitrates, latches address/data, and sequences one command at a time through a ready/done handshake.
- Returns read bursts to the read requester.
- Burst is 4 x 16-bit words, packed as word0 in bits [15:0].

Parameters:
ADDR_W, 26, address width, packed {ba[2:0], row[13:0], col[8:0]}
DATA_W, 64, burst width (4 words x 16 bits)
REF_PERIOD, 390, clock cycles between refresh ticks (7.8 us at 50 MHz)
REF_MAX_OWED, 8, refresh postpone limit; used only with REF_POSTPONE_EN

Ports:
clock  in  1  system clock, all logic on its rising edge
srst_n  in  1  synchronous active-low reset
init_done  in  1  core power-up init complete; level signal
wr_req  in  1  write request; held until wr_ack
wr_addr  in  ADDR_W  write burst address
wr_data  in  DATA_W  write burst data
wr_ack  out  1  one-cycle pulse; request and data captured
rd_req  in  1  read request; held until rd_ack
rd_addr  in  ADDR_W  read burst address
rd_ack  out  1  one-cycle pulse; request captured
rd_data  out  DATA_W  read burst, valid when rd_valid is high
rd_valid  out  1  one-cycle pulse
cmd_valid  out  1  command presented to the core
cmd_op  out  2  command opcode: 00 none, 01 write, 10 read, 11 refresh
cmd_addr  out  ADDR_W  latched address
cmd_wdata  out  DATA_W  latched write data
cmd_ready  in  1  core accepts the command this cycle
cmd_done  in  1  core finished the command; one-cycle pulse
cmd_rdata  in  DATA_W  read data, valid with cmd_done on reads
ref_overrun  out  1  sticky flag: a refresh tick was lost

Behaviour:
- Reset (srst_n low at a rising edge): every output is 0; FSM goes to IDLE; refresh counter, owed count and last_grant are cleared.
- Reset mid-operation aborts the command with no ack or done replay; the core is reset alongside.
- Refresh timer:
  - Held at 0 while init_done is low.
  - Otherwise counts 0..REF_PERIOD-1 and wraps.
  - The wrap cycle is a tick; a tick sets ref_pend.
  - If ref_pend is already set at a tick, ref_overrun is set. It is sticky until reset.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - No grant while init_done is low.
  - Priority: refresh pending > data requests.
  - Data requests are round-robin via last_grant. If both wr_req and rd_req are high, the one not granted last wins. Reset value favours write.
  - On a grant, the same edge loads cmd_op, cmd_addr and cmd_wdata (write only) and moves to ISSUE.
  - wr_ack or rd_ack goes high for exactly the following cycle. Refresh grant clears ref_pend and produces no ack.
  - Latency: req high at edge N -> ack high N..N+1 -> cmd_valid high from N.
- ISSUE:
  - cmd_valid is held high and cmd_op/cmd_addr/cmd_wdata are stable.
  - When cmd_ready is sampled high: cmd_valid <= 0, cmd_op <= 00, go to WAIT_DONE.
- WAIT_DONE:
  - Wait for cmd_done. cmd_done is ignored in other states.
  - For a read: rd_data <= cmd_rdata and rd_valid is pulsed for one cycle.
  - Return to IDLE. A new grant is possible on the edge after the return, so there is at least 1 idle cycle between commands.
  - rd_data holds its value until the next read completes.
- Requests are not sampled outside IDLE. The requester drops req on seeing ack. A req still high in IDLE after ack is treated as a new request.
- A tick arriving during ISSUE/WAIT_DONE is queued; ref_pend is serviced first on return to IDLE.

Optional Feature:
Macro: SDRAM_ARB_REF_POSTPONE_EN
- Defined:
  - ref_pend is replaced by a ref_owed counter, 0..REF_MAX_OWED.
  - A tick increments it. A refresh grant decrements it. A tick and a grant in the same cycle leave it unchanged.
  - Refresh is granted only when ref_owed>0 and either no data req is high or ref_owed==REF_MAX_OWED.
  - Owed refreshes drain back-to-back when the bus is idle.
  - A tick at ref_owed==REF_MAX_OWED sets ref_overrun; the counter stays saturated.
- Undefined: single-bit ref_pend with absolute refresh priority, as described above.

Test Plan:
- Reset/init: hold srst_n=0 for 3 cycles, then init_done=0 for 100 cycles with wr_req=1 -> all outputs 0, no wr_ack, cmd_valid=0.
- Single write: init_done=1, wr_req with addr 0x0000004, data 0x0003_0002_0001_0000, cmd_ready delayed 2 cycles, cmd_done 5 cycles later -> wr_ack one cycle after req; cmd_op=01 with matching addr/data held until ready; next grant no earlier than 1 cycle after done.
- Read return: rd_req with addr 0x0000008, core returns cmd_rdata 0x000B_000A_0009_0008 with cmd_done -> rd_valid one cycle, rd_data equals that value.
- Round robin: wr_req and rd_req held continuously for 6 grants -> grant order W,R,W,R,W,R.
- Refresh priority (feature off, REF_PERIOD=50): tick during an outstanding read -> refresh (cmd_op=11) issued before the waiting write. A command held in WAIT_DONE for 120 cycles -> ref_overrun=1 and it stays 1.
- Postpone (feature on, REF_MAX_OWED=8, REF_PERIOD=50): saturating wr_req traffic -> no refresh until ref_owed=8, then a refresh is forced. Drop requests -> remaining owed refreshes issue back-to-back down to 0.
